// File: rtl/regfile_wr_sched_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_wr_sched_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Starvation FSM: RUN gives the pipeline priority, YIELD forces one long-latency write.
  typedef enum logic {
    RUN   = 1'b0,
    YIELD = 1'b1
  } sched_state_e;

  // One-hot decode of a register address into a scoreboard mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Bundle of all request, hazard and write-port signals around the scheduler.
// Latency: n/a (wires only).
// Backpressure: l_ready/iss_ready/p_hold/dec_stall flow from slave to master.
interface regfile_wr_sched_if #(
  parameter int bit_width = 32
);
  import regfile_wr_sched_pkg::*;

  logic                 p_wr;
  reg_addr_t            p_rd;
  logic [bit_width-1:0] p_data;
  logic                 p_hold;
  logic                 l_valid;
  reg_addr_t            l_rd;
  logic [bit_width-1:0] l_data;
  logic                 l_ready;
  logic                 iss_valid;
  reg_addr_t            iss_rd;
  logic                 iss_ready;
  reg_addr_t            dec_rs;
  reg_addr_t            dec_rt;
  logic                 dec_stall;
  logic                 rf_wr;
  reg_addr_t            rf_reg;
  logic [bit_width-1:0] rf_data;
  logic                 proto_err;

  // CPU side: presents requests, consumes grants, stalls and the write port.
  modport master (
    output p_wr, p_rd, p_data, l_valid, l_rd, l_data, iss_valid, iss_rd, dec_rs, dec_rt,
    input  p_hold, l_ready, iss_ready, dec_stall, rf_wr, rf_reg, rf_data, proto_err
  );

  // Scheduler side.
  modport slave (
    input  p_wr, p_rd, p_data, l_valid, l_rd, l_data, iss_valid, iss_rd, dec_rs, dec_rt,
    output p_hold, l_ready, iss_ready, dec_stall, rf_wr, rf_reg, rf_data, proto_err
  );

endinterface

// File: rtl/regfile_wr_sched_reg_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations plus RAW/WAW lookups.
// Latency: set/clear visible the cycle after the event; lookups are combinational.
// Backpressure: o_iss_rdy low on WAW, o_dec_stall high on RAW.
module reg_scoreboard
  import regfile_wr_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_iss_vld,
  input  reg_addr_t i_iss_reg,
  input  logic      i_clr_vld,
  input  reg_addr_t i_clr_reg,
  input  reg_addr_t i_rs,
  input  reg_addr_t i_rt,
  output logic      o_iss_rdy,
  output logic      o_dec_stall
);

  // r0 is hardwired zero, so it can never be outstanding.
  localparam logic [NUM_REGS-1:0] R0_KEEP = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  // Lookups use registered busy only: a clearing write is not bypassed.
  assign o_iss_rdy   = !r_busy[i_iss_reg];
  assign o_dec_stall = ((i_rs != '0) && r_busy[i_rs]) || ((i_rt != '0) && r_busy[i_rt]);

  // Decode this cycle's accepted issue and long-latency completion into masks.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_iss_vld && o_iss_rdy && (i_iss_reg != '0)) w_set_mask = reg_onehot(i_iss_reg);
    if (i_clr_vld) w_clr_mask = reg_onehot(i_clr_reg);
  end

  // Clear first then set, so a same-cycle set of the same register wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & R0_KEEP;
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Shares the register-file write port between writeback and the long-latency unit.
// Latency: 0 cycles request to rf_*; p_hold/proto_err/busy are registered.
// Backpressure: l_ready grant, iss_ready on WAW, dec_stall on RAW; writeback has none.
module regfile_wr_sched
  import regfile_wr_sched_pkg::*;
#(
  parameter int bit_width  = 32,
  parameter int STARVE_LIM = 4
) (
  input logic               clk,
  input logic               rst,
  regfile_wr_sched_if.slave bus
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  sched_state_e         r_state;
  logic [3:0]           r_wait_cnt;
  logic                 r_p_hold;
  logic                 r_proto_err;
  logic                 w_p_grant;
  logic                 w_l_ready;
  logic                 w_l_xfer;
  logic                 w_rf_wr;
  reg_addr_t            w_rf_reg;
  logic [bit_width-1:0] w_rf_data;

  // Pipeline wins unless the FSM is forcing a yield.
  assign w_p_grant = bus.p_wr && !r_p_hold;
  assign w_l_ready = r_p_hold || !bus.p_wr;
  assign w_l_xfer  = bus.l_valid && w_l_ready;

  assign bus.l_ready   = w_l_ready;
  assign bus.p_hold    = r_p_hold;
  assign bus.proto_err = r_proto_err;
  assign bus.rf_wr     = w_rf_wr;
  assign bus.rf_reg    = w_rf_reg;
  assign bus.rf_data   = w_rf_data;

  // Steer the granted source onto the write port; zeros when idle.
  always_comb begin
    w_rf_wr   = 1'b0;
    w_rf_reg  = '0;
    w_rf_data = '0;
    if (w_p_grant) begin
      w_rf_wr   = 1'b1;
      w_rf_reg  = bus.p_rd;
      w_rf_data = bus.p_data;
    end else if (w_l_xfer) begin
      w_rf_wr   = 1'b1;
      w_rf_reg  = bus.l_rd;
      w_rf_data = bus.l_data;
    end
  end

  // Starvation FSM: count consecutive denials, then hold the pipeline for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_p_hold    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= r_proto_err | (bus.p_wr & r_p_hold);
      case (r_state)
        RUN: begin
          if (bus.l_valid && !w_l_ready) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
            if (r_wait_cnt + 4'd1 == LIM) begin
              r_state  <= YIELD;
              r_p_hold <= 1'b1;
            end
          end else begin
            r_wait_cnt <= '0;
          end
        end
        YIELD: begin
          // l_ready is forced high here, so either a transfer happens or l_valid is low.
          r_state    <= RUN;
          r_p_hold   <= 1'b0;
          r_wait_cnt <= '0;
        end
        default: begin
          r_state    <= RUN;
          r_p_hold   <= 1'b0;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_iss_vld   (bus.iss_valid),
    .i_iss_reg   (bus.iss_rd),
    .i_clr_vld   (w_l_xfer),
    .i_clr_reg   (bus.l_rd),
    .i_rs        (bus.dec_rs),
    .i_rt        (bus.dec_rt),
    .o_iss_rdy   (bus.iss_ready),
    .o_dec_stall (bus.dec_stall)
  );

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Scoreboard bench: driver pushes model-predicted outputs, monitor pops and compares.
// Latency: expected values apply to the same cycle as the stimulus.
// Backpressure: model tracks hold/denial/busy state from the rules directly.
module tb_regfile_wr_sched;
  import regfile_wr_sched_pkg::*;

  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_sched_if #(.bit_width(32)) bus ();

  regfile_wr_sched #(.bit_width(32), .STARVE_LIM(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        l_ready;
    logic        iss_ready;
    logic        dec_stall;
    logic        p_hold;
    logic        proto_err;
    logic        rf_wr;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  bit m_busy[32];
  int m_denied;
  bit m_hold;
  bit m_perr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_denied = 0;
    m_hold   = 1'b0;
    m_perr   = 1'b0;
  endtask

  // Apply one cycle of stimulus, predict outputs, then advance the model.
  task automatic step(input bit r, input bit pw, input logic [4:0] prd, input logic [31:0] pdat,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input bit iv, input logic [4:0] ird, input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    bit   lrdy, xfer, irdy;
    @(posedge clk);
    #1;
    rst           = r;
    bus.p_wr      = pw;
    bus.p_rd      = prd;
    bus.p_data    = pdat;
    bus.l_valid   = lv;
    bus.l_rd      = lrd;
    bus.l_data    = ldat;
    bus.iss_valid = iv;
    bus.iss_rd    = ird;
    bus.dec_rs    = rs;
    bus.dec_rt    = rt;
    if (!r) model_reset();

    lrdy = m_hold || !pw;
    xfer = lv && lrdy;
    irdy = !m_busy[ird];
    e.l_ready   = lrdy;
    e.iss_ready = irdy;
    e.dec_stall = (rs != 0 && m_busy[rs]) || (rt != 0 && m_busy[rt]);
    e.p_hold    = m_hold;
    e.proto_err = m_perr;
    if (pw && !m_hold) begin
      e.rf_wr = 1'b1; e.rf_reg = prd; e.rf_data = pdat;
    end else if (xfer) begin
      e.rf_wr = 1'b1; e.rf_reg = lrd; e.rf_data = ldat;
    end else begin
      e.rf_wr = 1'b0; e.rf_reg = '0; e.rf_data = '0;
    end
    exp_q.push_back(e);

    if (r) begin
      if (pw && m_hold) m_perr = 1'b1;
      if (m_hold) begin
        m_hold   = 1'b0;
        m_denied = 0;
      end else if (lv && !lrdy) begin
        m_denied++;
        if (m_denied == LIM) m_hold = 1'b1;
      end else begin
        m_denied = 0;
      end
      if (xfer) m_busy[lrd] = 1'b0;
      if (iv && irdy && ird != 0) m_busy[ird] = 1'b1;
    end
  endtask

  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("l_ready",   32'(bus.l_ready),   32'(e.l_ready));
        chk("iss_ready", 32'(bus.iss_ready), 32'(e.iss_ready));
        chk("dec_stall", 32'(bus.dec_stall), 32'(e.dec_stall));
        chk("p_hold",    32'(bus.p_hold),    32'(e.p_hold));
        chk("proto_err", 32'(bus.proto_err), 32'(e.proto_err));
        chk("rf_wr",     32'(bus.rf_wr),     32'(e.rf_wr));
        chk("rf_reg",    32'(bus.rf_reg),    32'(e.rf_reg));
        chk("rf_data",   bus.rf_data,        e.rf_data);
      end
    end
  end

  initial begin
    bus.p_wr = 0; bus.p_rd = 0; bus.p_data = 0;
    bus.l_valid = 0; bus.l_rd = 0; bus.l_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0; bus.dec_rs = 0; bus.dec_rt = 0;
    model_reset();

    // Reset state
    idle(0);
    idle(0);
    idle(1);

    // Pipeline beats long-latency unit, then starvation forces a yield on the 5th cycle
    for (int i = 0; i < 6; i++)
      step(1, 1, 5'd5, 32'hAAAA, 1, 5'd6, 32'h6666_0000 + i, 0, 0, 0, 0);

    // Make r9 busy, build up denials again, then reset asynchronously mid-operation
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
    for (int i = 0; i < LIM; i++)
      step(1, 1, 5'd3, 32'h1234, 1, 5'd12, 32'h5555, 0, 0, 5'd9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
    #1;
    chk("async_rst_p_hold",    32'(bus.p_hold),    32'd0);
    chk("async_rst_proto_err", 32'(bus.proto_err), 32'd0);
    chk("async_rst_dec_stall", 32'(bus.dec_stall), 32'd0);
    chk("async_rst_rf_wr",     32'(bus.rf_wr),     32'd0);
    idle(1);

    // RAW: issue r7, decode stalls until the cycle after its l transfer
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd2);
    step(1, 0, 0, 0, 1, 5'd7, 32'hC0DE, 0, 0, 5'd7, 5'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd2);

    // WAW: reissue r7 while busy; then set and clear of r7 in the same cycle
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    step(1, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 5'd7, 32'h78, 1, 5'd7, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7);
    step(1, 0, 0, 0, 1, 5'd7, 32'h79, 0, 0, 0, 0);

    // r0 never becomes busy
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    step(1, 1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with small register range to provoke collisions
    for (int n = 0; n < 1500; n++) begin
      bit r;
      r = ($urandom_range(0, 299) != 0);
      if (!r)
        idle(0);
      else
        step(1, $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
